// File: rtl/dram_responder_pkg.sv
// ---------------------------------------------------------------------------
// dram_responder_pkg : shared types and helpers for the DRAM responder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dram_responder_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_A    = 2'b01,
    RD_B    = 2'b10,
    RD_ILL  = 2'b11
  } rd_kind_e;

  // Full-width compare so aliasing high address bits never hit a valid word
  function automatic logic in_range(input logic [DATA_W-1:0] addr, input int depth);
    return int'(addr) < depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dram_responder_array.sv
// ---------------------------------------------------------------------------
// dram_responder_array : single-port DEPTH x 16 RAM, one write port, registered read
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dram_responder_array
  import dram_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-first: the registered read returns the word as it was before this edge
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dram_responder.sv
// ---------------------------------------------------------------------------
// dram_responder : fixed-latency memory responder for the core data bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] ar_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [1:0]        read_en,
  input  logic              write_en,
  output logic [DATA_W-1:0] dram_rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              addr_err,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [AW-1:0]     addr_q;
  logic              oor_q;
  logic [DATA_W-1:0] rdata_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;

  logic              ar_ok;
  logic              ld_ok;
  logic              rd_req;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // In IDLE the RAM port follows the incoming request so a read is already
  // fetched on the accept edge; while busy it holds the captured address.
  always_comb begin
    ar_ok     = in_range(ar_in, DEPTH);
    ld_ok     = in_range(load_addr, DEPTH);
    rd_req    = (read_en == RD_A) || (read_en == RD_B);
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_in;
    if (state_q == S_IDLE) begin
      if (load_en) begin
        ram_addr  = load_addr[AW-1:0];
        ram_wdata = load_data;
        ram_we    = ld_ok;
      end else begin
        ram_addr  = ar_in[AW-1:0];
        ram_we    = write_en && ar_ok;
      end
    end
  end

  dram_responder_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clock),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_en) begin
            err_q <= !ld_ok;
          end else if (write_en) begin
            state_q <= S_WRITE;
            busy_q  <= 1'b1;
            err_q   <= !ar_ok || (read_en != RD_NONE);
          end else if (rd_req) begin
            state_q <= S_READ;
            busy_q  <= 1'b1;
            cnt_q   <= 3'd0;
            addr_q  <= ar_in[AW-1:0];
            oor_q   <= !ar_ok;
            err_q   <= !ar_ok;
          end else if (read_en == RD_ILL) begin
            err_q <= 1'b1;
          end
        end
        S_READ: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            rdata_q <= oor_q ? '0 : ram_rdata;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dram_rdata  = rdata_q;
  assign rdata_valid = valid_q;
  assign busy        = busy_q;
  assign addr_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_responder.sv
// ---------------------------------------------------------------------------
// tb_dram_responder : timeline/scoreboard bench for dram_responder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dram_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int MAXC  = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] ar_in = '0;
  logic [15:0] wdata_in = '0;
  logic [1:0]  read_en = '0;
  logic        write_en = 1'b0;
  logic [15:0] dram_rdata;
  logic        rdata_valid;
  logic        busy;
  logic        addr_err;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;

  dram_responder #(
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ar_in       (ar_in),
    .wdata_in    (wdata_in),
    .read_en     (read_en),
    .write_en    (write_en),
    .dram_rdata  (dram_rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .addr_err    (addr_err),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          at;
  } rd_t;

  rd_t         exp_q[$];
  bit          exp_busy[MAXC];
  bit          exp_err[MAXC];
  logic [15:0] mem[DEPTH];
  bit          known[DEPTH];
  logic [15:0] exp_last = '0;
  int          checks = 0;
  int          failures = 0;

  function automatic void check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endfunction

  // Monitor: every cycle compare outputs against the expected timeline.
  always @(negedge clock) begin : mon
    logic v_exp;
    if (cyc < MAXC) begin
      v_exp = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        v_exp    = 1'b1;
        exp_last = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      check("rdata_valid", 16'(rdata_valid), 16'(v_exp));
      check("dram_rdata", dram_rdata, exp_last);
      check("busy", 16'(busy), 16'(exp_busy[cyc]));
      check("addr_err", 16'(addr_err), 16'(exp_err[cyc]));
    end
  end

  task automatic idle_inputs();
    load_en = 1'b0; load_addr = '0; load_data = '0;
    write_en = 1'b0; read_en = 2'b00; ar_in = '0; wdata_in = '0;
  endtask

  task automatic set_busy(input int c);
    if (c < MAXC) exp_busy[c] = 1'b1;
  endtask

  task automatic set_err(input int c);
    if (c < MAXC) exp_err[c] = 1'b1;
  endtask

  // Record the architectural effect of one request accepted at edge a.
  task automatic model_accept(input bit le, input logic [15:0] la, input logic [15:0] ld,
                              input bit we, input logic [1:0] re,
                              input logic [15:0] ar, input logic [15:0] wd, input int a);
    if (le) begin
      if (la < DEPTH) begin mem[la[7:0]] = ld; known[la[7:0]] = 1'b1; end
      else set_err(a);
    end else if (we) begin
      set_busy(a);
      if (ar < DEPTH) begin mem[ar[7:0]] = wd; known[ar[7:0]] = 1'b1; end
      if (ar >= DEPTH || re != 2'b00) set_err(a);
    end else if (re == 2'b01 || re == 2'b10) begin
      for (int k = 0; k < LAT; k++) set_busy(a + k);
      exp_q.push_back('{data: (ar < DEPTH) ? mem[ar[7:0]] : 16'h0000, at: a + LAT});
      if (ar >= DEPTH) set_err(a);
    end else if (re == 2'b11) begin
      set_err(a);
    end
  endtask

  task automatic op(input bit le, input logic [15:0] la, input logic [15:0] ld,
                    input bit we, input logic [1:0] re,
                    input logic [15:0] ar, input logic [15:0] wd);
    int a;
    @(negedge clock);
    a = cyc + 1;
    load_en = le; load_addr = la; load_data = ld;
    write_en = we; read_en = re; ar_in = ar; wdata_in = wd;
    model_accept(le, la, ld, we, re, ar, wd, a);
    @(negedge clock);
    idle_inputs();
    if (!le && !we && (re == 2'b01 || re == 2'b10)) repeat (LAT - 1) @(negedge clock);
  endtask

  // Level-held read: a new accept every LAT+1 cycles.
  task automatic held_read(input logic [15:0] ar, input int n);
    int a;
    @(negedge clock);
    a = cyc + 1;
    read_en = 2'b01; ar_in = ar;
    for (int k = 0; k < n; k++) model_accept(1'b0, '0, '0, 1'b0, 2'b01, ar, '0, a + k * (LAT + 1));
    repeat ((n - 1) * (LAT + 1) + 1) @(negedge clock);
    idle_inputs();
    repeat (LAT - 1) @(negedge clock);
  endtask

  task automatic reset_mid_read(input logic [15:0] ar);
    int a;
    @(negedge clock);
    a = cyc + 1;
    read_en = 2'b01; ar_in = ar;
    model_accept(1'b0, '0, '0, 1'b0, 2'b01, ar, '0, a);
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_last = '0;
    for (int c = cyc + 1; c < MAXC; c++) begin exp_busy[c] = 1'b0; exp_err[c] = 1'b0; end
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin : stim
    logic [15:0] ra;
    logic [15:0] dv;
    int          kind;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;

    op(1'b1, 16'd5, 16'd3, 1'b0, 2'b00, '0, '0);
    op(1'b0, '0, '0, 1'b0, 2'b01, 16'd5, '0);
    op(1'b0, '0, '0, 1'b1, 2'b00, 16'd7, 16'h1234);
    op(1'b0, '0, '0, 1'b0, 2'b10, 16'd7, '0);
    op(1'b1, 16'd44, 16'hBEEF, 1'b0, 2'b00, '0, '0);
    op(1'b0, '0, '0, 1'b0, 2'b01, 16'd300, '0);
    op(1'b0, '0, '0, 1'b1, 2'b00, 16'd300, 16'h5555);
    op(1'b0, '0, '0, 1'b0, 2'b01, 16'd44, '0);
    op(1'b0, '0, '0, 1'b1, 2'b01, 16'd9, 16'd2);
    op(1'b0, '0, '0, 1'b0, 2'b10, 16'd9, '0);
    op(1'b0, '0, '0, 1'b0, 2'b11, 16'd5, '0);
    op(1'b0, '0, '0, 1'b1, 2'b11, 16'd10, 16'h0077);
    op(1'b0, '0, '0, 1'b0, 2'b01, 16'd10, '0);
    op(1'b1, 16'd256, 16'hDEAD, 1'b0, 2'b00, '0, '0);
    op(1'b1, 16'd11, 16'hCAFE, 1'b1, 2'b01, 16'd12, 16'hF00D);
    op(1'b0, '0, '0, 1'b0, 2'b01, 16'd11, '0);
    held_read(16'd7, 3);
    reset_mid_read(16'd5);
    op(1'b0, '0, '0, 1'b0, 2'b01, 16'd5, '0);

    for (int i = 0; i < 100; i++) begin
      kind = int'($urandom_range(0, 5));
      ra   = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(256, 65535));
      dv   = 16'($urandom);
      case (kind)
        0: op(1'b1, ra, dv, 1'b0, 2'b00, '0, '0);
        1: op(1'b0, '0, '0, 1'b1, 2'b00, ra, dv);
        2, 3: begin
          if (ra < DEPTH && !known[ra[7:0]]) ra = 16'd5;
          op(1'b0, '0, '0, 1'b0, 2'($urandom_range(1, 2)), ra, '0);
        end
        4: op(1'b0, '0, '0, 1'b1, 2'($urandom_range(1, 3)), ra, dv);
        default: op(1'b0, '0, '0, 1'b0, 2'b11, ra, '0);
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end

    repeat (LAT + 3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_reads got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
